bn_stream_arbiter: RTL and testbench

- Shares one BN datapath lane between two requesters: A (forward activation stream) and B (backward gradient stream).
- Grants whole bursts (valid/ready/last) using round-robin arbitration.
- Drives the select line of the downstream 2:1 data multiplexer and steers the selected stream through an internal mux_2 instance into a one-entry registered output stage.
- A watchdog limits burst length so neither requester can hold the lane indefinitely.

---
 rtl/bn_stream_arbiter.sv | 150 +++++++++++++++
 tb/tb_bn_stream_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_stream_arbiter.sv
// bn_stream_arbiter: round-robin burst arbiter that shares one BN datapath lane
// between a forward activation stream (A) and a backward gradient stream (B).
// Whole bursts are granted; a watchdog forces release after MAX_BURST beats.
// Optional build macro: BN_ARB_STATS_EN adds per-source grant counters.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | no grant; arbitrate between pending requesters
//  GRANT_A | lane owned by A until a_last or watchdog release
//  GRANT_B | lane owned by B until b_last or watchdog release

module mux_2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

module bn_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_last,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_last,
  output logic                  b_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  o_ready,
  output logic                  sel,
  output logic                  burst_err
`ifdef BN_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      a_grant_cnt,
  output logic [CNT_W-1:0]      b_grant_cnt
`endif
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t                state, state_nxt;
  logic                  last_winner;   // 0 = A, 1 = B
  logic [BW-1:0]         beat_cnt;
  logic                  can_load;
  logic                  src_valid;
  logic                  src_last;
  logic                  take;
  logic                  forced;
  logic                  enter_grant;
  logic [DATA_WIDTH-1:0] mux_out;

  assign sel      = (state == GRANT_B);
  assign can_load = !o_valid || o_ready;
  assign a_ready  = (state == GRANT_A) && can_load;
  assign b_ready  = (state == GRANT_B) && can_load;

  mux_2 #(.W(DATA_WIDTH)) u_mux (
    .a (a_data),
    .b (b_data),
    .s (sel),
    .y (mux_out)
  );

  // Handshake, watchdog and next-state decode
  always_comb begin
    state_nxt = state;
    src_valid = sel ? b_valid : a_valid;
    src_last  = sel ? b_last  : a_last;
    take      = (state != IDLE) && src_valid && can_load;
    forced    = (beat_cnt == BW'(MAX_BURST - 1)) && !src_last;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = last_winner ? GRANT_A : GRANT_B;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
      end
      GRANT_A, GRANT_B: begin
        if (take && (src_last || forced)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    enter_grant = (state == IDLE) && (state_nxt != IDLE);
  end

  // State register, round-robin memory and burst beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      beat_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (enter_grant) begin
        last_winner <= (state_nxt == GRANT_B);
        beat_cnt    <= '0;
      end else if (take) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  // One-entry output register; load and drain in the same cycle keeps full rate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= take && forced;
      if (take) begin
        o_valid <= 1'b1;
        o_data  <= mux_out;
        o_last  <= src_last || forced;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef BN_ARB_STATS_EN
  // Grant statistics, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else if (enter_grant) begin
      if (state_nxt == GRANT_A) a_grant_cnt <= a_grant_cnt + CNT_W'(1);
      else                      b_grant_cnt <= b_grant_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_bn_stream_arbiter.sv
// Bench for bn_stream_arbiter (MAX_BURST = 4). Stats ports connected when
// BN_ARB_STATS_EN is defined.
module tb_bn_stream_arbiter;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic o_ready = 1'b1;
  logic a_ready, b_ready, o_valid, o_last, sel, burst_err;
  logic [DW-1:0] o_data;
`ifdef BN_ARB_STATS_EN
  logic [CW-1:0] a_grant_cnt, b_grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_pulses = 0;
  logic [DW:0] q[$];
  int out_cyc[$];
  int first_take[2];
  int last_take[2];
  int take_n[2];

  bn_stream_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready),
    .sel(sel), .burst_err(burst_err)
`ifdef BN_ARB_STATS_EN
    , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard whenever a beat is handed downstream
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        checks++;
        if (a_ready && b_ready) begin
          errors++; $display("FAIL ready_exclusive: a_ready=%0b b_ready=%0b, required not both 1", a_ready, b_ready);
        end
        if (burst_err === 1'b1) err_pulses++;
        if (o_valid && o_ready) begin
          out_cyc.push_back(cyc);
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL unexpected_beat: o_data=%h with empty scoreboard", o_data);
          end else begin
            e = q.pop_front();
            if (o_data !== e[DW-1:0] || o_last !== e[DW]) begin
              errors++; $display("FAIL out_beat: got data=%h last=%0b, required data=%h last=%0b", o_data, o_last, e[DW-1:0], e[DW]);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drop(input bit is_b);
    if (is_b) begin b_valid = 1'b0; b_last = 1'b0; end
    else      begin a_valid = 1'b0; a_last = 1'b0; end
  endtask

  // Present an n-beat burst; expected beat (with watchdog-forced last) is pushed at take
  task automatic send(input bit is_b, input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
    int cnt = 0;
    int wc;
    logic [DW-1:0] d;
    logic el;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin drop(is_b); return; end
      d = base + step * DW'(i);
      if (is_b) begin b_valid = 1'b1; b_data = d; b_last = (i == n - 1); end
      else      begin a_valid = 1'b1; a_data = d; a_last = (i == n - 1); end
      #1;
      wc = 0;
      while (!(is_b ? b_ready : a_ready)) begin
        @(negedge clk); #1;
        wc++;
        if (rst) begin drop(is_b); return; end
        if (wc > 200) begin
          errors++; checks++;
          $display("FAIL ready_timeout: src=%0d beat=%0d never readied", is_b, i);
          drop(is_b); return;
        end
      end
      if (rst) begin drop(is_b); return; end
      cnt++;
      el = (i == n - 1) || (cnt == MB);
      if (el) cnt = 0;
      q.push_back({el, d});
      if (take_n[is_b] == 0) first_take[is_b] = cyc;
      last_take[is_b] = cyc;
      take_n[is_b]++;
      checks++;
      if (sel !== is_b) begin
        errors++; $display("FAIL sel_at_take: sel=%0b, required %0b", sel, is_b);
      end
    end
    @(negedge clk);
    drop(is_b);
  endtask

  task automatic clear_takes();
    for (int s = 0; s < 2; s++) begin first_take[s] = 0; last_take[s] = 0; take_n[s] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    clear_takes();
  endtask

  task automatic drain(input string name);
    int wc = 0;
    while ((q.size() != 0 || o_valid) && wc < 100) begin @(negedge clk); wc++; end
    @(negedge clk); #2;
    checks++;
    if (q.size() != 0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL %s_drain: %0d beats outstanding, o_valid=%0b, required 0/0", name, q.size(), o_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({o_valid, o_last, sel, a_ready, b_ready, burst_err} !== 6'b0 || o_data !== '0) begin
      errors++; $display("FAIL reset_values: ov=%0b ol=%0b sel=%0b ar=%0b br=%0b be=%0b od=%h, required all 0",
                         o_valid, o_last, sel, a_ready, b_ready, burst_err, o_data);
    end
`ifdef BN_ARB_STATS_EN
    checks++;
    if (a_grant_cnt !== '0 || b_grant_cnt !== '0) begin
      errors++; $display("FAIL reset_stats: a=%0d b=%0d, required 0 0", a_grant_cnt, b_grant_cnt);
    end
`endif
    @(negedge clk); rst = 1'b0;
    clear_takes();
  endtask

  task automatic test_single();
    out_cyc.delete();
    err_pulses = 0;
    send(1'b0, 3, 16'h0011, 16'h0011);
    drain("single");
    checks++;
    if (out_cyc.size() != 3) begin
      errors++; $display("FAIL single_count: %0d beats out, required 3", out_cyc.size());
    end else begin
      checks++;
      if (out_cyc[0] - first_take[0] != 1 || out_cyc[1] - out_cyc[0] != 1 || out_cyc[2] - out_cyc[1] != 1) begin
        errors++; $display("FAIL single_timing: take=%0d out=%0d,%0d,%0d, required consecutive after take",
                           first_take[0], out_cyc[0], out_cyc[1], out_cyc[2]);
      end
    end
    checks++;
    if (a_ready !== 1'b0 || sel !== 1'b0 || err_pulses != 0) begin
      errors++; $display("FAIL single_idle: a_ready=%0b sel=%0b burst_err_pulses=%0d, required 0 0 0", a_ready, sel, err_pulses);
    end
  endtask

  task automatic test_contention();
    do_reset();
    fork
      send(1'b0, 2, 16'hA000, 16'h0001);
      send(1'b1, 2, 16'hB000, 16'h0001);
    join
    drain("contention1");
    checks++;
    if (!(last_take[0] < first_take[1]) || first_take[1] - last_take[0] != 2) begin
      errors++; $display("FAIL contention_order1: a_last_take=%0d b_first_take=%0d, required A first with gap 2",
                         last_take[0], first_take[1]);
    end
`ifdef BN_ARB_STATS_EN
    checks++;
    if (a_grant_cnt !== CW'(1) || b_grant_cnt !== CW'(1)) begin
      errors++; $display("FAIL stats_round1: a=%0d b=%0d, required 1 1", a_grant_cnt, b_grant_cnt);
    end
`endif
    clear_takes();
    fork
      send(1'b0, 2, 16'hA100, 16'h0001);
      send(1'b1, 2, 16'hB100, 16'h0001);
    join
    drain("contention2");
    checks++;
    if (!(last_take[0] < first_take[1])) begin
      errors++; $display("FAIL contention_order2: a_last_take=%0d b_first_take=%0d, required A first", last_take[0], first_take[1]);
    end
`ifdef BN_ARB_STATS_EN
    checks++;
    if (a_grant_cnt !== CW'(2) || b_grant_cnt !== CW'(2)) begin
      errors++; $display("FAIL stats_round2: a=%0d b=%0d, required 2 2", a_grant_cnt, b_grant_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int wc = 0;
    fork
      send(1'b1, 4, 16'hB200, 16'h0001);
      begin
        do begin @(negedge clk); #1; wc++; end while (!o_valid && wc < 50);
        @(negedge clk); o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #2;
          checks++;
          if (b_ready !== 1'b0 || o_valid !== 1'b1) begin
            errors++; $display("FAIL stall_ready: b_ready=%0b o_valid=%0b, required 0 1", b_ready, o_valid);
          end
          @(negedge clk);
        end
        o_ready = 1'b1;
      end
    join
    drain("backpressure");
  endtask

  task automatic test_watchdog();
    err_pulses = 0;
    clear_takes();
    send(1'b0, 6, 16'hC000, 16'h0001);
    drain("watchdog");
    checks++;
    if (err_pulses != 1) begin
      errors++; $display("FAIL burst_err_pulses: %0d, required 1", err_pulses);
    end
    checks++;
    if (take_n[0] != 6) begin
      errors++; $display("FAIL watchdog_beats: %0d taken, required 6", take_n[0]);
    end
  endtask

  task automatic test_mux();
    for (int r = 0; r < 2; r++) begin
      fork
        send(1'b0, 2, 16'hAAAA, 16'h0000);
        send(1'b1, 2, 16'h5555, 16'h0000);
      join
    end
    drain("mux");
  endtask

  task automatic test_reset_mid();
    int wc = 0;
    clear_takes();
    fork
      send(1'b1, 4, 16'hD000, 16'h0001);
      begin
        do begin @(negedge clk); #2; wc++; end while (take_n[1] < 2 && wc < 50);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, sel, b_ready, burst_err} !== 4'b0) begin
          errors++; $display("FAIL async_reset: ov=%0b sel=%0b br=%0b be=%0b, required 0 0 0 0", o_valid, sel, b_ready, burst_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    q.delete();
    clear_takes();
    fork
      send(1'b0, 1, 16'hE000, 16'h0000);
      send(1'b1, 1, 16'hE100, 16'h0000);
    join
    drain("after_reset");
    checks++;
    if (take_n[0] != 1 || take_n[1] != 1 || !(first_take[0] < first_take[1])) begin
      errors++; $display("FAIL post_reset_grant: a_take=%0d b_take=%0d, required A granted first", first_take[0], first_take[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_mux();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
